// File: rtl/nxt_bus_arbiter.sv
// Round-robin arbiter sharing the L_NEXT memory port between the I-cache and the D-cache.
// Optional macro ARB_STATS_EN adds saturating grant/stall/timeout statistics outputs.
module nxt_bus_arbiter #(
    parameter int ADDRW   = 26,
    parameter int CMDW    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ic_req,
    input  logic [ADDRW-1:0] ic_addr,
    input  logic [CMDW-1:0]  ic_cmd,
    output logic             ic_gnt,
    output logic             ic_done,
    input  logic             dc_req,
    input  logic [ADDRW-1:0] dc_addr,
    input  logic [CMDW-1:0]  dc_cmd,
    output logic             dc_gnt,
    output logic             dc_done,
    output logic             nxt_valid,
    output logic [ADDRW-1:0] nxt_addr,
    output logic [CMDW-1:0]  nxt_cmd,
    input  logic             nxt_ready,
    input  logic             nxt_ack,
    output logic             err
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]      ic_grants,
    output logic [31:0]      dc_grants,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      timeouts
`endif
);

    // state  | meaning
    // IDLE   | no transaction; arbitrate on any request
    // ISSUE  | request presented on L_NEXT, waiting for nxt_ready
    // WAIT   | request accepted, counting cycles until nxt_ack or timeout
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam int             CNTW   = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] C_TMO = CNTW'(TIMEOUT);
    localparam logic           OWN_IC = 1'b0;
    localparam logic           OWN_DC = 1'b1;

    state_t           r_state;
    logic             r_owner;
    logic             r_last;
    logic [CNTW-1:0]  r_cnt;
    logic             r_ic_gnt;
    logic             r_dc_gnt;
    logic             r_ic_done;
    logic             r_dc_done;
    logic             r_err;
    logic             r_valid;
    logic [ADDRW-1:0] r_addr;
    logic [CMDW-1:0]  r_cmd;

    logic w_pick_dc;
    logic w_gnt_ic;
    logic w_gnt_dc;
    logic w_cnt_hit;

    // DC wins only when IC is absent or IC owned the previous transaction.
    assign w_pick_dc = dc_req & (~ic_req | (r_last == OWN_IC));
    assign w_gnt_dc  = (r_state == S_IDLE) & w_pick_dc;
    assign w_gnt_ic  = (r_state == S_IDLE) & ic_req & ~w_pick_dc;
    assign w_cnt_hit = (r_cnt == C_TMO - CNTW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_IC;
            r_last    <= OWN_DC;
            r_cnt     <= '0;
            r_ic_gnt  <= 1'b0;
            r_dc_gnt  <= 1'b0;
            r_ic_done <= 1'b0;
            r_dc_done <= 1'b0;
            r_err     <= 1'b0;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_cmd     <= '0;
        end else begin
            r_ic_gnt  <= 1'b0;
            r_dc_gnt  <= 1'b0;
            r_ic_done <= 1'b0;
            r_dc_done <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_ic || w_gnt_dc) begin
                        r_owner  <= w_gnt_dc ? OWN_DC : OWN_IC;
                        r_ic_gnt <= w_gnt_ic;
                        r_dc_gnt <= w_gnt_dc;
                        r_valid  <= 1'b1;
                        r_addr   <= w_gnt_dc ? dc_addr : ic_addr;
                        r_cmd    <= w_gnt_dc ? dc_cmd : ic_cmd;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (nxt_ready) begin
                        r_valid <= 1'b0;
                        r_addr  <= '0;
                        r_cmd   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != C_TMO) r_cnt <= r_cnt + CNTW'(1);
                    // An ack arriving on the timeout cycle still completes cleanly.
                    if (nxt_ack || w_cnt_hit) begin
                        r_ic_done <= (r_owner == OWN_IC);
                        r_dc_done <= (r_owner == OWN_DC);
                        r_err     <= ~nxt_ack;
                        r_last    <= r_owner;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ic_gnt    = r_ic_gnt;
    assign dc_gnt    = r_dc_gnt;
    assign ic_done   = r_ic_done;
    assign dc_done   = r_dc_done;
    assign err       = r_err;
    assign nxt_valid = r_valid;
    assign nxt_addr  = r_addr;
    assign nxt_cmd   = r_cmd;

`ifdef ARB_STATS_EN
    logic [31:0] r_ic_grants;
    logic [31:0] r_dc_grants;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_timeouts;
    logic        w_stall;
    logic        w_tmo;

    assign w_stall = (r_state == S_ISSUE) & ~nxt_ready;
    assign w_tmo   = (r_state == S_WAIT) & w_cnt_hit & ~nxt_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ic_grants    <= '0;
            r_dc_grants    <= '0;
            r_stall_cycles <= '0;
            r_timeouts     <= '0;
        end else begin
            if (w_gnt_ic && (r_ic_grants != '1))    r_ic_grants    <= r_ic_grants + 32'd1;
            if (w_gnt_dc && (r_dc_grants != '1))    r_dc_grants    <= r_dc_grants + 32'd1;
            if (w_stall && (r_stall_cycles != '1))  r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_tmo && (r_timeouts != '1))        r_timeouts     <= r_timeouts + 32'd1;
        end
    end

    assign ic_grants    = r_ic_grants;
    assign dc_grants    = r_dc_grants;
    assign stall_cycles = r_stall_cycles;
    assign timeouts     = r_timeouts;
`endif

endmodule

// File: tb/tb_nxt_bus_arbiter.sv
// Scoreboard bench for nxt_bus_arbiter: stimulus queues expected gnt/done events with
// their cycle stamps, a negedge monitor pops and compares them as the DUT pulses.
module tb_nxt_bus_arbiter;
    localparam int ADDRW = 26;
    localparam int CMDW  = 2;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ic_req = 1'b0, dc_req = 1'b0;
    logic [ADDRW-1:0] ic_addr = '0, dc_addr = '0;
    logic [CMDW-1:0]  ic_cmd = '0, dc_cmd = '0;
    logic             ic_gnt, dc_gnt, ic_done, dc_done, err;
    logic             nxt_valid;
    logic [ADDRW-1:0] nxt_addr;
    logic [CMDW-1:0]  nxt_cmd;
    logic             nxt_ready = 1'b0, nxt_ack = 1'b0;
`ifdef ARB_STATS_EN
    logic [31:0] ic_grants, dc_grants, stall_cycles, timeouts;
`endif

    nxt_bus_arbiter #(.ADDRW(ADDRW), .CMDW(CMDW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_cmd(ic_cmd), .ic_gnt(ic_gnt), .ic_done(ic_done),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_cmd(dc_cmd), .dc_gnt(dc_gnt), .dc_done(dc_done),
        .nxt_valid(nxt_valid), .nxt_addr(nxt_addr), .nxt_cmd(nxt_cmd),
        .nxt_ready(nxt_ready), .nxt_ack(nxt_ack), .err(err)
`ifdef ARB_STATS_EN
        , .ic_grants(ic_grants), .dc_grants(dc_grants),
        .stall_cycles(stall_cycles), .timeouts(timeouts)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit               kind;   // 0 = grant, 1 = done
        bit               dc;
        bit               errf;
        logic [ADDRW-1:0] addr;
        logic [CMDW-1:0]  cmd;
        int               cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (!nxt_valid && (nxt_addr != '0 || nxt_cmd != '0)) begin
                n_fail++;
                $display("FAIL idle_bus: got addr=%07h cmd=%0d with valid=0, required 0/0 (cyc %0d)",
                         nxt_addr, nxt_cmd, cyc);
            end
            n_tests++;
            if ((int'(ic_gnt) + int'(dc_gnt) + int'(ic_done) + int'(dc_done)) > 1) begin
                n_fail++;
                $display("FAIL one_pulse: got gnt=%b%b done=%b%b, required at most one (cyc %0d)",
                         ic_gnt, dc_gnt, ic_done, dc_done, cyc);
            end
            if (ic_gnt || dc_gnt || ic_done || dc_done || err) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got gnt=%b%b done=%b%b err=%b at cyc %0d, required none",
                             ic_gnt, dc_gnt, ic_done, dc_done, err, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (((ic_gnt | dc_gnt) == mon_e.kind) || ((dc_gnt | dc_done) != mon_e.dc) ||
                        (err != mon_e.errf) || (nxt_addr !== mon_e.addr) || (nxt_cmd !== mon_e.cmd) ||
                        (nxt_valid != !mon_e.kind) || (cyc != mon_e.cyc)) begin
                        n_fail++;
                        $display("FAIL event: got gnt=%b%b done=%b%b err=%b addr=%07h cmd=%0d valid=%b cyc=%0d; required kind=%0d dc=%0d err=%0d addr=%07h cmd=%0d cyc=%0d",
                                 ic_gnt, dc_gnt, ic_done, dc_done, err, nxt_addr, nxt_cmd, nxt_valid, cyc,
                                 mon_e.kind, mon_e.dc, mon_e.errf, mon_e.addr, mon_e.cmd, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input bit kind, input bit dc, input bit errf,
                        input logic [ADDRW-1:0] a, input logic [CMDW-1:0] c, input int cy);
        ev_t e;
        e.kind = kind; e.dc = dc; e.errf = errf; e.addr = a; e.cmd = c; e.cyc = cy;
        exp_q.push_back(e);
    endtask

    // One full transaction from IDLE. ack_k = WAIT edge carrying nxt_ack (0 = let it time out).
    task automatic run(input bit dc, input logic [ADDRW-1:0] a, input logic [CMDW-1:0] c,
                       input int n_stall, input int ack_k, input bit raise_other);
        int acc_cyc;
        if (dc) begin dc_req = 1'b1; dc_addr = a; dc_cmd = c; end
        else    begin ic_req = 1'b1; ic_addr = a; ic_cmd = c; end
        nxt_ready = 1'b0;
        push(1'b0, dc, 1'b0, a, c, cyc + 1);
        tick();
        nxt_ack = 1'b0;
        if (dc) dc_req = 1'b0; else ic_req = 1'b0;
        for (int i = 0; i < n_stall; i++) begin
            nxt_ack = (i == 2);
            tick();
            chk("stall_valid", 32'(nxt_valid), 32'd1);
            chk("stall_addr", 32'(nxt_addr), 32'(a));
            chk("stall_cmd", 32'(nxt_cmd), 32'(c));
        end
        nxt_ack = 1'b0;
        nxt_ready = 1'b1;
        tick();
        acc_cyc = cyc;
        nxt_ready = 1'b0;
        chk("accept_valid_low", 32'(nxt_valid), 32'd0);
        if (raise_other) begin
            if (dc) ic_req = 1'b1; else dc_req = 1'b1;
        end
        if (ack_k > 0) begin
            push(1'b1, dc, 1'b0, '0, '0, acc_cyc + ack_k);
            repeat (ack_k - 1) tick();
            nxt_ack = 1'b1;
            tick();
            nxt_ack = 1'b0;
        end else begin
            push(1'b1, dc, 1'b1, '0, '0, acc_cyc + TMO);
            repeat (TMO) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        mon_en = 1'b1;
        chk("reset_ctrl", 32'({ic_gnt, dc_gnt, ic_done, dc_done, nxt_valid, err}), 32'd0);
        chk("reset_addr", 32'(nxt_addr), 32'd0);
        chk("reset_cmd", 32'(nxt_cmd), 32'd0);
`ifdef ARB_STATS_EN
        chk("reset_stats", ic_grants | dc_grants | stall_cycles | timeouts, 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Simultaneous requests after reset: IC first, then strict alternation.
        dc_req = 1'b1; dc_addr = 26'h2000001; dc_cmd = 2'd2;
        run(1'b0, 26'h1000001, 2'd1, 0, 2, 1'b0);
        run(1'b1, 26'h2000001, 2'd2, 0, 1, 1'b0);
        dc_req = 1'b1; dc_addr = 26'h2000003; dc_cmd = 2'd3;
        run(1'b0, 26'h1000004, 2'd0, 0, 2, 1'b0);
        run(1'b1, 26'h2000003, 2'd3, 0, 1, 1'b0);

        // IC-only request with ack on the third WAIT edge.
        run(1'b0, 26'h0001234, 2'd1, 0, 3, 1'b0);

        // Tie after an IC transaction goes to DC; IC then follows.
        ic_req = 1'b1; ic_addr = 26'h0F0F0F0; ic_cmd = 2'd3;
        run(1'b1, 26'h2ABCDEF, 2'd0, 0, 1, 1'b0);
        run(1'b0, 26'h0F0F0F0, 2'd3, 0, 1, 1'b0);

        // Five stall cycles in ISSUE, with a stray ack during the stall.
        run(1'b1, 26'h1555555, 2'd2, 5, 2, 1'b0);
`ifdef ARB_STATS_EN
        chk("stall_cycles", stall_cycles, 32'd5);
`endif

        // Timeout, then a stray ack in IDLE must produce nothing.
        run(1'b0, 26'h0000ABC, 2'd3, 0, 0, 1'b0);
        nxt_ack = 1'b1;
        tick();
        nxt_ack = 1'b0;
        repeat (3) tick();
`ifdef ARB_STATS_EN
        chk("ic_grants", ic_grants, 32'd5);
        chk("dc_grants", dc_grants, 32'd4);
        chk("timeouts", timeouts, 32'd1);
`endif

        // Ack exactly on the timeout edge; DC raised during IC WAIT waits for the done cycle.
        dc_addr = 26'h0246802; dc_cmd = 2'd1;
        run(1'b0, 26'h1357913, 2'd2, 0, TMO, 1'b1);
        run(1'b1, 26'h0246802, 2'd1, 0, 1, 1'b0);

        // Reset while in WAIT with a pending DC request.
        ic_req = 1'b1; ic_addr = 26'h3333333; ic_cmd = 2'd1;
        push(1'b0, 1'b0, 1'b0, 26'h3333333, 2'd1, cyc + 1);
        tick();
        ic_req = 1'b0;
        nxt_ready = 1'b1;
        tick();
        nxt_ready = 1'b0;
        dc_req = 1'b1; dc_addr = 26'h3000300; dc_cmd = 2'd2;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_wait_ctrl", 32'({ic_gnt, dc_gnt, ic_done, dc_done, nxt_valid, err}), 32'd0);
        chk("rst_wait_addr", 32'(nxt_addr), 32'd0);
`ifdef ARB_STATS_EN
        chk("rst_wait_stats", ic_grants | dc_grants | stall_cycles | timeouts, 32'd0);
`endif
        reset = 1'b0;
        nxt_ack = 1'b1;
        run(1'b1, 26'h3000300, 2'd2, 0, 2, 1'b0);

        repeat (5) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
